// File: rtl/mem_stage_lsu.sv
// Data-memory stage: load/store through a req/ack memory port with lane steering,
// load extension, WB->MEM store forwarding, misalign/timeout exceptions and MEM/WB register.
module mem_stage_lsu #(
  parameter int ADDR_W     = 32,
  parameter int REG_W      = 5,
  parameter int TIMEOUT    = 16,
  parameter int BIG_ENDIAN = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_sdata,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_wb_en,
  input  logic              fwd_wb_en,
  input  logic [REG_W-1:0]  fwd_wb_rd,
  input  logic [31:0]       fwd_wb_data,
  input  logic [REG_W-1:0]  in_rt,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              out_valid,
  output logic              out_wb_en,
  output logic [REG_W-1:0]  out_rd,
  output logic [31:0]       out_data,
  output logic [1:0]        out_exc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;

  typedef enum logic {IDLE, REQ} state_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return ~off[0];
      2'd2:    return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'd0:    m = (BIG_ENDIAN != 0) ? (4'b1000 >> off) : (4'b0001 << off);
      2'd1:    m = ((BIG_ENDIAN != 0) == (off[1] == 1'b0)) ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replication puts the value in every lane, so the byte enables alone pick the target.
  function automatic logic [31:0] steer(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] off,
                                          input logic uns, input logic [31:0] rd);
    logic [1:0]         lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    lane = (BIG_ENDIAN != 0) ? ~off : off;
    b    = rd[{lane, 3'b000} +: 8];
    h    = lane[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  logic [ADDR_W-1:0]  addr_p1;
  logic [1:0]         size_p1;
  logic               uns_p1;
  logic               load_p1;
  logic               wb_en_p1;
  logic [REG_W-1:0]   rd_p1;

  logic               mem_op;
  logic               aligned;
  logic               accept;
  logic               timeout_hit;
  logic               fwd_hit;
  logic [31:0]        sdata_sel;

  assign mem_op      = in_load | in_store;
  assign aligned     = is_aligned(in_size, in_addr[1:0]);
  assign accept      = (state == IDLE) && in_valid && mem_op && aligned;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign fwd_hit     = fwd_wb_en && (fwd_wb_rd == in_rt) && (in_rt != '0);
  assign sdata_sel   = fwd_hit ? fwd_wb_data : in_sdata;

  // Stall releases in the completing REQ cycle so upstream advances on that same edge.
  assign stall = accept || ((state == REQ) && !dm_ack && !timeout_hit);

  // Accept stage: request attributes captured for the REQ phase
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_p1  <= in_addr;
      size_p1  <= in_size;
      uns_p1   <= in_unsigned;
      load_p1  <= in_load;
      wb_en_p1 <= in_wb_en;
      rd_p1    <= in_rd;
    end
  end

  // Request stage and MEM/WB register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_be     <= 4'd0;
      dm_addr   <= '0;
      dm_wdata  <= 32'd0;
      out_valid <= 1'b0;
      out_wb_en <= 1'b0;
      out_rd    <= '0;
      out_data  <= 32'd0;
      out_exc   <= EXC_NONE;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mem_op) begin
              out_valid <= 1'b1;
              out_wb_en <= in_wb_en;
              out_rd    <= in_rd;
              out_data  <= 32'(in_addr);
              out_exc   <= EXC_NONE;
            end else if (!aligned) begin
              out_valid <= 1'b1;
              out_wb_en <= 1'b0;
              out_rd    <= in_rd;
              out_data  <= 32'(in_addr);
              out_exc   <= EXC_MISALIGN;
            end else begin
              state    <= REQ;
              cnt      <= '0;
              dm_req   <= 1'b1;
              dm_we    <= ~in_load;
              dm_be    <= lane_mask(in_size, in_addr[1:0]);
              dm_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
              dm_wdata <= in_load ? 32'd0 : steer(in_size, sdata_sel);
            end
          end
        end
        REQ: begin
          if (dm_ack || timeout_hit) begin
            state     <= IDLE;
            cnt       <= '0;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_be     <= 4'd0;
            dm_addr   <= '0;
            dm_wdata  <= 32'd0;
            out_valid <= 1'b1;
            out_rd    <= rd_p1;
            if (dm_ack) begin
              out_wb_en <= wb_en_p1;
              out_data  <= load_p1 ? extract(size_p1, addr_p1[1:0], uns_p1, dm_rdata)
                                   : 32'(addr_p1);
              out_exc   <= EXC_NONE;
            end else begin
              out_wb_en <= 1'b0;
              out_data  <= 32'(addr_p1);
              out_exc   <= EXC_TIMEOUT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: vector table driven through a req/ack memory model,
// MEM/WB results checked against a scoreboard queue, plus hand-written reset sequences.
module tb_mem_stage_lsu;

  logic        CLK;
  logic        RESET;
  logic        in_valid, in_load, in_store, in_unsigned, in_wb_en;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_sdata;
  logic [4:0]  in_rd, in_rt, fwd_wb_rd;
  logic        fwd_wb_en;
  logic [31:0] fwd_wb_data;
  logic        stall, dm_req, dm_we, dm_ack;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        out_valid, out_wb_en;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [1:0]  out_exc;

  mem_stage_lsu #(.ADDR_W(32), .REG_W(5), .TIMEOUT(16), .BIG_ENDIAN(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_load(in_load), .in_store(in_store), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_sdata(in_sdata), .in_rd(in_rd),
    .in_wb_en(in_wb_en), .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_data(fwd_wb_data), .in_rt(in_rt), .stall(stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .out_wb_en(out_wb_en), .out_rd(out_rd), .out_data(out_data),
    .out_exc(out_exc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic ld; logic st; logic [1:0] size; logic uns;
    logic [31:0] addr; logic [31:0] sdata; logic [4:0] rt;
    logic fen; logic [4:0] frd; logic [31:0] fdata;
    logic [4:0] rd; logic wb;
    int waits; logic [31:0] rdata;
    int exp_nreq; int exp_nstall; logic exp_we; logic [3:0] exp_be; logic [31:0] exp_wdata;
    logic [31:0] exp_data; logic chk_data; logic [1:0] exp_exc; logic exp_wb;
  } vec_t;

  typedef struct {
    logic [4:0] rd; logic wb; logic [31:0] data; logic chk; logic [1:0] exc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[17];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RESET && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got out_valid=1 data=%h want no result", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_rd", out_rd, e.rd);
        chk("out_wb_en", out_wb_en, e.wb);
        chk("out_exc", out_exc, e.exc);
        if (e.chk) chk("out_data", out_data, e.data);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int   nreq, nstall, c;
    logic st, done;
    exp_t e;
    @(posedge CLK); #1;
    in_load = v.ld; in_store = v.st; in_size = v.size; in_unsigned = v.uns;
    in_addr = v.addr; in_sdata = v.sdata; in_rt = v.rt; fwd_wb_en = v.fen;
    fwd_wb_rd = v.frd; fwd_wb_data = v.fdata; in_rd = v.rd; in_wb_en = v.wb;
    in_valid = 1'b1;
    e.rd = v.rd; e.wb = v.exp_wb; e.data = v.exp_data; e.chk = v.chk_data; e.exc = v.exp_exc;
    sb.push_back(e);
    nreq = 0; nstall = 0; done = 1'b0; c = 0;
    while (!done && c < 60) begin
      @(negedge CLK);
      if (dm_req) begin
        nreq++;
        chk($sformatf("v%0d_dm_we", idx), dm_we, v.exp_we);
        chk($sformatf("v%0d_dm_be", idx), dm_be, v.exp_be);
        chk($sformatf("v%0d_dm_addr", idx), dm_addr, {v.addr[31:2], 2'b00});
        if (v.st && !v.ld) chk($sformatf("v%0d_dm_wdata", idx), dm_wdata, v.exp_wdata);
        dm_ack   = (v.waits >= 0) && (nreq == v.waits + 1);
        dm_rdata = v.rdata;
      end
      #1;
      st = stall;
      if (st) nstall++;
      @(posedge CLK); #1;
      dm_ack = 1'b0;
      if (!st) begin
        in_valid = 1'b0;
        done = 1'b1;
      end
      c++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL v%0d_release: got stall held 60 cycles want release", idx);
    end
    chk($sformatf("v%0d_req_cycles", idx), nreq, v.exp_nreq);
    chk($sformatf("v%0d_stall_cycles", idx), nstall, v.exp_nstall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ld st sz uns addr sdata rt fen frd fdata rd wb waits rdata nreq nstall we be wdata data chk exc wbexp
    vecs[0]  = '{1,0,2,0,'h100,0,0,0,0,0,3,1,0,'hDEADBEEF,1,1,0,'hF,0,'hDEADBEEF,1,0,1};
    vecs[1]  = '{1,0,0,0,'h101,0,0,0,0,0,4,1,0,'h12F45678,1,1,0,'b0100,0,'hFFFFFFF4,1,0,1};
    vecs[2]  = '{1,0,0,1,'h101,0,0,0,0,0,5,1,0,'h12F45678,1,1,0,'b0100,0,'h000000F4,1,0,1};
    vecs[3]  = '{0,1,1,0,'h202,'h0000ABCD,2,0,0,0,0,0,3,0,4,4,1,'b0011,'hABCDABCD,'h202,1,0,0};
    vecs[4]  = '{0,1,2,0,'h300,'hAAAAAAAA,7,1,7,'h11223344,0,0,0,0,1,1,1,'hF,'h11223344,'h300,1,0,0};
    vecs[5]  = '{0,1,2,0,'h304,'hAAAAAAAA,0,1,0,'h11223344,0,0,1,0,2,2,1,'hF,'hAAAAAAAA,'h304,1,0,0};
    vecs[6]  = '{1,0,2,0,'h103,0,0,0,0,0,6,1,0,0,0,0,0,0,0,0,0,1,0};
    vecs[7]  = '{1,0,2,0,'h400,0,0,0,0,0,8,1,-1,0,16,16,0,'hF,0,0,0,2,0};
    vecs[8]  = '{0,0,2,0,'h12345678,0,0,0,0,0,9,1,0,0,0,0,0,0,0,'h12345678,1,0,1};
    vecs[9]  = '{1,0,1,0,'h102,0,0,0,0,0,10,1,1,'h12348001,2,2,0,'b0011,0,'hFFFF8001,1,0,1};
    vecs[10] = '{1,0,1,1,'h100,0,0,0,0,0,11,1,0,'h80011234,1,1,0,'b1100,0,'h00008001,1,0,1};
    vecs[11] = '{0,1,0,0,'h503,'h000000A5,3,0,0,0,0,0,0,0,1,1,1,'b0001,'hA5A5A5A5,'h503,1,0,0};
    vecs[12] = '{1,0,0,0,'h100,0,0,0,0,0,12,1,0,'h7F000000,1,1,0,'b1000,0,'h0000007F,1,0,1};
    vecs[13] = '{1,0,3,0,'h100,0,0,0,0,0,13,1,0,0,0,0,0,0,0,0,0,1,0};
    vecs[14] = '{1,0,1,0,'h101,0,0,0,0,0,14,1,0,0,0,0,0,0,0,0,0,1,0};
    vecs[15] = '{1,1,2,0,'h600,'h55555555,0,0,0,0,15,1,0,'hCAFEF00D,1,1,0,'hF,0,'hCAFEF00D,1,0,1};
    vecs[16] = '{1,0,2,0,'h700,0,0,0,0,0,16,1,15,'h01020304,16,16,0,'hF,0,'h01020304,1,0,1};

    RESET = 1'b1;
    in_valid = 0; in_load = 0; in_store = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_sdata = 0; in_rd = 0; in_rt = 0; in_wb_en = 0;
    fwd_wb_en = 0; fwd_wb_rd = 0; fwd_wb_data = 0; dm_ack = 0; dm_rdata = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dm_req", dm_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_dm_be", dm_be, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Reset while a load is waiting for its acknowledge
    @(posedge CLK); #1;
    in_load = 1; in_store = 0; in_size = 2; in_unsigned = 0; in_addr = 'h800;
    in_rd = 1; in_wb_en = 1; fwd_wb_en = 0; in_valid = 1;
    @(posedge CLK); #1;
    chk("midrst_req_before", dm_req, 1);
    @(negedge CLK);
    RESET = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_dm_req", dm_req, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_stall", stall, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    dm_ack = 1'b1;
    dm_rdata = 'h99999999;
    #1;
    chk("late_ack_stall", stall, 0);
    @(posedge CLK); #1;
    dm_ack = 1'b0;
    chk("late_ack_out_valid", out_valid, 0);
    chk("late_ack_dm_req", dm_req, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("late_ack_quiet%0d", k), out_valid, 0);
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised data-memory stage for the 5-stage pipeline. It is the successor to the single-cycle MEM stage and replaces the combinational memory access with a request/acknowledge data-memory interface. It performs byte/half/word load extraction with sign/zero extension, store byte-lane steering, WB→MEM store-data forwarding, misalignment and timeout detection, and a stall to the upstream stages. It ends in the MEM/WB pipeline register.

Parameters:
ADDR_W, 32, data-memory byte address width
REG_W, 5, register-file index width
TIMEOUT, 16, max cycles waiting for dm_ack before bus error (>=1)
BIG_ENDIAN, 1, 1: byte offset 0 maps to data[31:24]; 0: offset 0 maps to data[7:0]

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous, active-high reset
in_valid  in  1  EX/MEM entry valid
in_load  in  1  entry is a load
in_store  in  1  entry is a store (in_load and in_store both high is treated as a load)
in_size  in  2  0=byte, 1=half, 2=word, 3=reserved (flags misaligned)
in_unsigned  in  1  zero-extend loads
in_addr  in  ADDR_W  effective address / ALU result
in_sdata  in  32  store data from register B
in_rd  in  REG_W  destination register
in_wb_en  in  1  entry writes back
fwd_wb_en  in  1  WB stage writing
fwd_wb_rd  in  REG_W  WB destination
fwd_wb_data  in  32  WB write data
in_rt  in  REG_W  source register of store data
stall  out  1  hold upstream stages
dm_req  out  1  memory request
dm_we  out  1  write request
dm_be  out  4  byte enables, bit3 = data[31:24]
dm_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
dm_wdata  out  32  lane-steered store data
dm_ack  in  1  memory completes the request this cycle
dm_rdata  in  32  read word, valid when dm_ack
out_valid  out  1  MEM/WB valid
out_wb_en  out  1  MEM/WB write-back enable
out_rd  out  REG_W  MEM/WB destination
out_data  out  32  load result or passed-through ALU result
out_exc  out  2  0=none, 1=misaligned, 2=bus timeout

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset mid-transaction drops dm_req immediately. A late dm_ack after reset is ignored.
- FSM states:
  - IDLE: accept the entry when in_valid.
    - Non-memory entry: registered to out_* at the next edge, with out_data=in_addr and 1-cycle latency.
    - Aligned memory entry: latch address, size, unsigned, rd, wb_en and steered store data; go to REQ.
    - Misaligned memory entry: no memory access. Registered next edge with out_exc=1, out_wb_en=0, out_valid=1.
  - REQ: dm_req=1, and dm_we/dm_be/dm_addr/dm_wdata are held stable. The counter increments each cycle.
    - dm_ack: register the result (load extract, or store with out_data=addr) to out_*, out_exc=0, return to IDLE.
    - Counter reaches TIMEOUT without ack: out_valid=1, out_exc=2, out_wb_en=0, dm_req drops, return to IDLE.
- Memory-op latency: accept edge, then at least one REQ cycle, then result at the edge of the ack cycle. Zero-wait memory gives 2 cycles.
- stall=1 in REQ, and combinationally in IDLE when an aligned memory entry is offered. Upstream holds in_* stable while stall=1.
- out_valid=0 on any cycle where no result is registered.
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Size 3 is always misaligned.
- Lane mapping (BIG_ENDIAN=1):
  - Byte offset k maps to data[31-8k -: 8].
  - Half offset 0 maps to [31:16], half offset 2 maps to [15:0].
  - dm_be: byte = 4'b1000>>k; half = 4'b1100 (offset 0) or 4'b0011 (offset 2); word = 4'b1111.
  - Store data is replicated into the selected lanes.
- With BIG_ENDIAN=0, the lane mapping is mirrored.
- Load extract: the selected byte or half is sign-extended, or zero-extended when in_unsigned. Words pass unchanged. Loads drive dm_be with the same mask as a store of that size.
- Forwarding: the store data source is fwd_wb_data when fwd_wb_en && fwd_wb_rd==in_rt && in_rt!=0; otherwise it is in_sdata. Forwarding is sampled at the accept edge.
- Simultaneous dm_ack and timeout on the same cycle: ack wins.

Test Plan:
- Word load at addr 0x100, dm_ack on the first REQ cycle, dm_rdata=0xDEADBEEF → dm_be=4'hF, dm_addr=0x100; out_data=0xDEADBEEF 2 edges after accept; stall high for 1 cycle.
- LB addr 0x101 with dm_rdata=0x12F45678 → dm_be=4'b0100, out_data=0xFFFFFFF4. The same access as LBU → out_data=0x000000F4.
- SH addr 0x202 with in_sdata=0x0000ABCD, ack after 3 wait cycles → dm_we=1, dm_be=4'b0011, dm_wdata=0xABCDABCD; stall high 4 cycles.
- Store with in_rt=7, fwd_wb_en=1, fwd_wb_rd=7, fwd_wb_data=0x11223344 → SW dm_wdata=0x11223344. The same case with in_rt=0 → in_sdata is used.
- Misaligned case: LW at addr 0x103 → no dm_req; the next edge gives out_exc=1, out_wb_en=0. Timeout case: no dm_ack for TIMEOUT=16 cycles → out_exc=2, dm_req drops.
- Reset pulse asserted while in REQ → dm_req=0 immediately, out_valid=0. A dm_ack arriving one cycle after reset release produces no output.
